// File: rtl/param_memory.sv
// Parametrised synchronous RAM; shared read/write address, init pattern preloaded after reset.
// Latency: reads return rdata/rd_valid one cycle after rd_en; writes land at the request edge.
// Backpressure: none; requests while busy are dropped, otherwise every request is accepted.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   wr_en, rd_en, addr    write/read requests on a shared word address
//   wdata                 write data
//   rdata, rd_valid       registered read data and its one-cycle valid pulse
//   busy                  high while the init pattern is being written
//   addr_err              one-cycle pulse for an accepted request with addr >= DEPTH
//   par_err               parity mismatch on read, aligned with rd_valid
// Optional feature macro: MEM_PARITY_EN (stores an even-parity bit per word).
module param_memory #(
  parameter int          DW        = 8,
  parameter int          DEPTH     = 4,
  parameter int unsigned INIT_BASE = 32'hAA,
  parameter int unsigned INIT_STEP = 32'h11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     addr_err,
  output logic                     par_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

`ifdef MEM_PARITY_EN
  localparam int MW = DW + 1;
  function automatic logic [MW-1:0] make_entry(input logic [DW-1:0] d);
    return {^d, d};
  endfunction
`else
  localparam int MW = DW;
  function automatic logic [MW-1:0] make_entry(input logic [DW-1:0] d);
    return d;
  endfunction
`endif

  typedef enum logic {INIT, READY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   init_ptr;
  logic [DW-1:0]   init_val;
  logic [MW-1:0]   mem [DEPTH];
  logic [MW-1:0]   rd_word;
  logic            in_range;
  logic            rd_acc;
  logic            wr_acc;

  // FSM: INIT walks init_ptr over every word once, then READY until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (init_ptr == LAST_PTR) state_nxt = READY;
      end
      READY: state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // Pattern arithmetic is done in DW bits so it wraps mod 2^DW.
  assign init_val = DW'(INIT_BASE) + DW'(INIT_STEP) * DW'(init_ptr);

  // Address decode only matters for non-power-of-2 depths.
  assign in_range = {1'b0, addr} < DEPTH_W;
  assign rd_acc   = (state == READY) && rd_en;
  assign wr_acc   = (state == READY) && wr_en;
  assign rd_word  = in_range ? mem[addr] : '0;

  // Storage has no reset; the init FSM rewrites every word after reset.
  // Nonblocking write gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[init_ptr] <= make_entry(init_val);
      end else if (wr_en && in_range) begin
        mem[addr] <= make_entry(wdata);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      addr_err <= (rd_acc || wr_acc) && !in_range;
      if (rd_acc) rdata <= rd_word[DW-1:0];
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err <= 1'b0;
    end else begin
      par_err <= rd_acc && in_range && ((^rd_word[DW-1:0]) != rd_word[DW]);
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_memory.sv
module tb_param_memory;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DW=8, DEPTH=4.
  logic        reset = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        rd_valid, busy, addr_err, par_err;

  // Non-power-of-2 instance: DW=16, DEPTH=5.
  logic        reset5 = 1'b1, wr_en5 = 1'b0, rd_en5 = 1'b0;
  logic [2:0]  addr5 = '0;
  logic [15:0] wdata5 = '0;
  logic [15:0] rdata5;
  logic        rd_valid5, busy5, addr_err5, par_err5;

  int checks = 0;
  int failures = 0;

  param_memory dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .busy(busy),
    .addr_err(addr_err), .par_err(par_err)
  );

  param_memory #(.DW(16), .DEPTH(5)) dut5 (
    .clk(clk), .reset(reset5), .wr_en(wr_en5), .rd_en(rd_en5), .addr(addr5),
    .wdata(wdata5), .rdata(rdata5), .rd_valid(rd_valid5), .busy(busy5),
    .addr_err(addr_err5), .par_err(par_err5)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n, n5;
    reset = 1'b1; reset5 = 1'b1;
    cyc;
    checks++; if (rdata !== 8'h00)  begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
    checks++; if (par_err !== 1'b0)  begin failures++; $display("FAIL reset_par_err got=%b exp=0", par_err); end
    reset = 1'b0; reset5 = 1'b0;
    n = 0; n5 = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1)  n++;
      if (busy5 === 1'b1) n5++;
      cyc;
    end
    checks++; if (n != 4)  begin failures++; $display("FAIL busy_cycles got=%0d exp=4", n); end
    checks++; if (n5 != 5) begin failures++; $display("FAIL busy_cycles_d5 got=%0d exp=5", n5); end
  endtask

  // T1 plus back-to-back reads: rd_valid stays high every cycle.
  task automatic test_init_reads;
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      cyc;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL init_rd_valid[%0d] got=%b exp=1", i, rd_valid); end
      checks++; if (rdata !== exp[i])  begin failures++; $display("FAIL init_rdata[%0d] got=%h exp=%h", i, rdata, exp[i]); end
      checks++; if (par_err !== 1'b0)  begin failures++; $display("FAIL init_par_err[%0d] got=%b exp=0", i, par_err); end
    end
    rd_en = 1'b0;
    cyc;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL idle_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rdata !== 8'hDD)   begin failures++; $display("FAIL rdata_hold got=%h exp=DD", rdata); end
  endtask

  // T2
  task automatic test_write;
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'h5A, 8'hDD};
    wr_en = 1'b1; addr = 2'd2; wdata = 8'h5A;
    cyc;
    wr_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL write_no_valid got=%b exp=0", rd_valid); end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      cyc;
      checks++; if (rdata !== exp[i] || rd_valid !== 1'b1) begin
        failures++; $display("FAIL write_read[%0d] got=%h/%b exp=%h/1", i, rdata, rd_valid, exp[i]);
      end
    end
    rd_en = 1'b0;
    cyc;
  endtask

  // T3
  task automatic test_same_addr;
    wr_en = 1'b1; rd_en = 1'b1; addr = 2'd1; wdata = 8'h33;
    cyc;
    wr_en = 1'b0;
    checks++; if (rdata !== 8'hBB || rd_valid !== 1'b1) begin
      failures++; $display("FAIL rbw_old got=%h/%b exp=BB/1", rdata, rd_valid);
    end
    cyc;
    checks++; if (rdata !== 8'h33 || rd_valid !== 1'b1) begin
      failures++; $display("FAIL rbw_new got=%h/%b exp=33/1", rdata, rd_valid);
    end
    rd_en = 1'b0;
    cyc;
  endtask

  // T4
  task automatic test_out_of_range;
    logic [15:0] exp [5] = '{16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 16'h00EE};
    rd_en5 = 1'b1; addr5 = 3'd4;
    cyc;
    checks++; if (rdata5 !== 16'h00EE || rd_valid5 !== 1'b1 || addr_err5 !== 1'b0) begin
      failures++; $display("FAIL d5_word4 got=%h/%b/%b exp=00ee/1/0", rdata5, rd_valid5, addr_err5);
    end
    addr5 = 3'd6;
    cyc;
    checks++; if (rdata5 !== 16'h0000 || rd_valid5 !== 1'b1 || addr_err5 !== 1'b1) begin
      failures++; $display("FAIL d5_oor_read got=%h/%b/%b exp=0000/1/1", rdata5, rd_valid5, addr_err5);
    end
    rd_en5 = 1'b0; wr_en5 = 1'b1; addr5 = 3'd7; wdata5 = 16'h1234;
    cyc;
    wr_en5 = 1'b0;
    checks++; if (addr_err5 !== 1'b1 || rd_valid5 !== 1'b0) begin
      failures++; $display("FAIL d5_oor_write got=%b/%b exp=1/0", addr_err5, rd_valid5);
    end
    cyc;
    checks++; if (addr_err5 !== 1'b0) begin failures++; $display("FAIL d5_err_pulse got=%b exp=0", addr_err5); end
    rd_en5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr5 = 3'(i);
      cyc;
      checks++; if (rdata5 !== exp[i] || rd_valid5 !== 1'b1) begin
        failures++; $display("FAIL d5_read[%0d] got=%h/%b exp=%h/1", i, rdata5, rd_valid5, exp[i]);
      end
    end
    rd_en5 = 1'b0;
    cyc;
  endtask

  // T5
  task automatic test_reset_mid_op;
    int n;
    wr_en = 1'b1; addr = 2'd0; wdata = 8'h77;
    cyc;
    wr_en = 1'b0; rd_en = 1'b1;
    cyc;
    checks++; if (rdata !== 8'h77) begin failures++; $display("FAIL pre_reset_read got=%h exp=77", rdata); end
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b1 || rdata !== 8'h00) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%h exp=0/1/00", rd_valid, busy, rdata);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL busy_read_ignored got=%b exp=0", rd_valid); end
      cyc;
      n++;
    end
    checks++; if (busy !== 1'b0 || n != 4) begin
      failures++; $display("FAIL rebusy got busy=%b cycles=%0d exp=0/4", busy, n);
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL last_busy_edge got=%b exp=0", rd_valid); end
    cyc;
    checks++; if (rdata !== 8'hAA || rd_valid !== 1'b1) begin
      failures++; $display("FAIL post_reset_read got=%h/%b exp=AA/1", rdata, rd_valid);
    end
    rd_en = 1'b0;
    cyc;
  endtask

  // T6
  task automatic test_parity;
    wr_en = 1'b1; addr = 2'd3; wdata = 8'h0F;
    cyc;
    wr_en = 1'b0; rd_en = 1'b1;
    cyc;
    checks++; if (par_err !== 1'b0 || rdata !== 8'h0F) begin
      failures++; $display("FAIL parity_clean got=%b/%h exp=0/0f", par_err, rdata);
    end
`ifdef MEM_PARITY_EN
    rd_en = 1'b0;
    dut.mem[3] = dut.mem[3] ^ 9'h001;
    rd_en = 1'b1;
    cyc;
    checks++; if (par_err !== 1'b1 || rd_valid !== 1'b1 || rdata !== 8'h0E) begin
      failures++; $display("FAIL parity_flip got=%b/%b/%h exp=1/1/0e", par_err, rd_valid, rdata);
    end
`endif
    rd_en = 1'b0;
    cyc;
    checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL parity_idle got=%b exp=0", par_err); end
  endtask

  initial begin
    test_reset;
    test_init_reads;
    test_write;
    test_same_addr;
    test_out_of_range;
    test_reset_mid_op;
    test_parity;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
